// File: rtl/debouncer_pkg.sv
// Shared types and helpers for the debouncer array: per-channel FSM state
// encoding and the counter-width helper used to size the debounce counters.
package debouncer_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_e;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int count_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, ZERO/WAIT1/ONE/WAIT0 FSM with a
// stability counter, edge pulses and (with LONG_PRESS_EN defined) long-press detection.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES   = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy,
    output logic debounced,
    output logic p_edge,
    output logic n_edge,
    output logic long_press
);

    localparam int CW = count_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_q;
    db_state_e       state;
    db_state_e       next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            debounced_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= noisy;
            sync_q    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ZERO;
            cnt         <= '0;
            debounced_q <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            debounced_q <= debounced;
        end
    end

    // Each WAIT state leaves at the terminal count, so the counter never wraps.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            ZERO: begin
                if (sync_q) begin
                    next_state = WAIT1;
                    cnt_next   = '0;
                end
            end
            WAIT1: begin
                if (!sync_q) begin
                    next_state = ZERO;
                end else if (cnt == CNT_LAST) begin
                    next_state = ONE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ONE: begin
                if (!sync_q) begin
                    next_state = WAIT0;
                    cnt_next   = '0;
                end
            end
            WAIT0: begin
                if (sync_q) begin
                    next_state = ONE;
                end else if (cnt == CNT_LAST) begin
                    next_state = ZERO;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                next_state = ZERO;
                cnt_next   = '0;
            end
        endcase
    end

    assign debounced = (state == ONE) || (state == WAIT0);
    assign p_edge    = debounced & ~debounced_q;
    assign n_edge    = ~debounced & debounced_q;

`ifdef LONG_PRESS_EN
    localparam int LW = count_width(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LP_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LP_PRE = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lp_cnt;
    logic          lp_pulse;

    // Counts accepted-high cycles; a WAIT0 glitch keeps debounced high so it does not restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lp_cnt   <= '0;
            lp_pulse <= 1'b0;
        end else if (!debounced) begin
            lp_cnt   <= '0;
            lp_pulse <= 1'b0;
        end else begin
            if (lp_cnt != LP_MAX) begin
                lp_cnt <= lp_cnt + LW'(1);
            end
            lp_pulse <= (lp_cnt == LP_PRE);
        end
    end

    assign long_press = lp_pulse;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debouncer_array.sv
// Array of CH independent debounce channels sharing one clock and reset.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module debouncer_array
    import debouncer_pkg::*;
#(
    parameter int CH            = 4,
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int LONG_CYCLES   = 100_000_000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] noisy,
    output logic [CH-1:0] debounced,
    output logic [CH-1:0] p_edge,
    output logic [CH-1:0] n_edge,
    output logic [CH-1:0] any_edge,
    output logic [CH-1:0] long_press
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .noisy      (noisy[i]),
            .debounced  (debounced[i]),
            .p_edge     (p_edge[i]),
            .n_edge     (n_edge[i]),
            .long_press (long_press[i])
        );
    end

    assign any_edge = p_edge | n_edge;

endmodule

// File: tb/tb_debouncer_array.sv
// Randomised and directed bench for debouncer_array against a run-length reference
// model; long-press expectations follow whether LONG_PRESS_EN is defined.
module tb_debouncer_array;

    localparam int CH     = 4;
    localparam int STABLE = 8;
    localparam int LONG   = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [CH-1:0] noisy = '0;
    logic [CH-1:0] debounced;
    logic [CH-1:0] p_edge;
    logic [CH-1:0] n_edge;
    logic [CH-1:0] any_edge;
    logic [CH-1:0] long_press;

    always #5 clk = ~clk;

    debouncer_array #(
        .CH            (CH),
        .STABLE_CYCLES (STABLE),
        .LONG_CYCLES   (LONG)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .noisy      (noisy),
        .debounced  (debounced),
        .p_edge     (p_edge),
        .n_edge     (n_edge),
        .any_edge   (any_edge),
        .long_press (long_press)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: an input level is accepted once the level seen two edges late
    // has disagreed with the accepted level on STABLE+1 consecutive edges.
    logic [CH-1:0] seen_q [2];
    logic [CH-1:0] m_deb = '0;
    logic [CH-1:0] m_old = '0;
    logic [CH-1:0] m_seen = '0;
    logic [CH-1:0] m_p = '0;
    logic [CH-1:0] m_n = '0;
    logic [CH-1:0] m_lp = '0;
    int            run_mis [CH];
    int            run_hi  [CH];

    initial begin
        seen_q[0] = '0;
        seen_q[1] = '0;
        for (int i = 0; i < CH; i++) begin
            run_mis[i] = 0;
            run_hi[i]  = 0;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q[0] = '0;
            seen_q[1] = '0;
            m_deb = '0;
            m_p   = '0;
            m_n   = '0;
            m_lp  = '0;
            for (int i = 0; i < CH; i++) begin
                run_mis[i] = 0;
                run_hi[i]  = 0;
            end
        end else begin
            m_old     = m_deb;
            m_seen    = seen_q[1];
            seen_q[1] = seen_q[0];
            seen_q[0] = noisy;
            for (int i = 0; i < CH; i++) begin
                if (m_seen[i] != m_deb[i]) begin
                    run_mis[i]++;
                    if (run_mis[i] == STABLE + 1) begin
                        m_deb[i]   = m_seen[i];
                        run_mis[i] = 0;
                    end
                end else begin
                    run_mis[i] = 0;
                end
                run_hi[i] = m_old[i] ? run_hi[i] + 1 : 0;
`ifdef LONG_PRESS_EN
                m_lp[i] = m_old[i] && (run_hi[i] == LONG);
`else
                m_lp[i] = 1'b0;
`endif
            end
            m_p = m_deb & ~m_old;
            m_n = ~m_deb & m_old;
        end
    end

    int cyc = 0;
    int pcnt [CH];
    int ncnt [CH];
    int lcnt [CH];
    int rise2 = -1;
    int lp2   = -1;

    task automatic clearCounts();
        for (int i = 0; i < CH; i++) begin
            pcnt[i] = 0;
            ncnt[i] = 0;
            lcnt[i] = 0;
        end
        rise2 = -1;
        lp2   = -1;
    endtask

    always @(negedge clk) begin
        checkOutput("debounced", 32'(debounced), 32'(m_deb));
        checkOutput("p_edge", 32'(p_edge), 32'(m_p));
        checkOutput("n_edge", 32'(n_edge), 32'(m_n));
        checkOutput("any_edge", 32'(any_edge), 32'(m_p | m_n));
        checkOutput("long_press", 32'(long_press), 32'(m_lp));
        checkOutput("p_and_n", 32'(p_edge & n_edge), 32'd0);
        for (int i = 0; i < CH; i++) begin
            pcnt[i] += int'(p_edge[i]);
            ncnt[i] += int'(n_edge[i]);
            lcnt[i] += int'(long_press[i]);
        end
        if (p_edge[2]) rise2 = cyc;
        if (long_press[2]) lp2 = cyc;
        cyc++;
    end

    // Drives a level then lets `cycles` rising edges pass, returning 2 ns after the last one.
    task automatic applyStimulus(input logic [CH-1:0] val, input int cycles);
        noisy = val;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_deb"}, 32'(debounced), 32'd0);
        checkOutput({tag, "_pn"}, 32'(p_edge | n_edge | any_edge), 32'd0);
        checkOutput({tag, "_lp"}, 32'(long_press), 32'd0);
    endtask

    logic [CH-1:0] lvl;
    logic [CH-1:0] glitch;

    initial begin
        clearCounts();
        #2 reset_n = 1'b0;
        #1 checkAllZero("reset_init");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        applyStimulus('0, 20);

        // Clean press on channel 0: accepted on edge STABLE+3 = 11.
        applyStimulus(4'b0001, 10);
        checkOutput("ch0_edge10_deb", 32'(debounced[0]), 32'd0);
        applyStimulus(4'b0001, 1);
        checkOutput("ch0_edge11_deb", 32'(debounced[0]), 32'd1);
        checkOutput("ch0_edge11_p", 32'(p_edge[0]), 32'd1);
        checkOutput("ch0_edge11_any", 32'(any_edge[0]), 32'd1);
        applyStimulus(4'b0001, 1);
        checkOutput("ch0_edge12_p", 32'(p_edge[0]), 32'd0);
        checkOutput("ch0_edge12_any", 32'(any_edge[0]), 32'd0);

        // Channel 1 chatter shorter than the stability window.
        clearCounts();
        for (int r = 0; r < 6; r++) begin
            applyStimulus(4'b0011, 5);
            applyStimulus(4'b0001, 5);
        end
        applyStimulus(4'b0001, 20);
        checkOutput("ch1_glitch_p", 32'(pcnt[1]), 32'd0);
        checkOutput("ch1_glitch_n", 32'(ncnt[1]), 32'd0);
        checkOutput("ch1_glitch_deb", 32'(debounced[1]), 32'd0);

        // Channel 2 held for 50 cycles then released.
        clearCounts();
        applyStimulus(4'b0101, 50);
        applyStimulus(4'b0001, 60);
        checkOutput("ch2_p_count", 32'(pcnt[2]), 32'd1);
        checkOutput("ch2_n_count", 32'(ncnt[2]), 32'd1);
`ifdef LONG_PRESS_EN
        checkOutput("ch2_lp_count", 32'(lcnt[2]), 32'd1);
        checkOutput("ch2_lp_delay", 32'(lp2 - rise2), 32'(LONG));
`else
        checkOutput("ch2_lp_count", 32'(lcnt[2]), 32'd0);
`endif

        // All channels rise together.
        applyStimulus('0, 30);
        applyStimulus(4'b1111, 10);
        checkOutput("all_edge10_deb", 32'(debounced), 32'd0);
        applyStimulus(4'b1111, 1);
        checkOutput("all_edge11_deb", 32'(debounced), 32'hF);
        checkOutput("all_edge11_p", 32'(p_edge), 32'hF);

        // Reset in the middle of a WAIT1 count discards progress.
        applyStimulus('0, 30);
        applyStimulus(4'b1111, 7);
        reset_n = 1'b0;
        #1 checkAllZero("reset_mid");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        applyStimulus(4'b1111, 10);
        checkOutput("rst_edge10_deb", 32'(debounced), 32'd0);
        applyStimulus(4'b1111, 1);
        checkOutput("rst_edge11_deb", 32'(debounced), 32'hF);
        checkOutput("rst_edge11_p", 32'(p_edge), 32'hF);

        // Random levels with occasional toggles, single-cycle glitches and resets.
        lvl = noisy;
        for (int c = 0; c < 2500; c++) begin
            glitch = '0;
            for (int i = 0; i < CH; i++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 3) lvl[i] = ~lvl[i];
                else if (r < 6) glitch[i] = 1'b1;
            end
            if (c == 900 || c == 1800) begin
                reset_n = 1'b0;
                #1 checkAllZero("reset_rand");
                repeat (2) @(posedge clk);
                #2 reset_n = 1'b1;
            end
            applyStimulus(lvl ^ glitch, 1);
        end
        applyStimulus(lvl, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/debouncer_array.md
DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 2_000_000: cycles an input must hold a level before acceptance (20 ms at 100 MHz), minimum 2.
REQ-003 Parameter LONG_CYCLES, default 100_000_000: cycles of accepted-high level before the long-press pulse, minimum 1.
REQ-004 clk  input  1  single system clock, all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 noisy  input  CH  raw asynchronous button/switch levels, bit i = channel i.
REQ-007 debounced  output  CH  accepted stable level per channel.
REQ-008 p_edge  output  CH  one-cycle pulse on an accepted 0->1 change.
REQ-009 n_edge  output  CH  one-cycle pulse on an accepted 1->0 change.
REQ-010 any_edge  output  CH  bitwise OR of p_edge and n_edge.
REQ-011 long_press  output  CH  one-cycle pulse when a channel has been accepted-high for LONG_CYCLES cycles.

Function
REQ-012 Each noisy bit SHALL pass a 2-flop synchroniser before any other logic; channels share no state.
REQ-013 Per-channel FSM SHALL have states ZERO, WAIT1, ONE, WAIT0; debounced = 1 in ONE and WAIT0 only.
REQ-014 ZERO: sync=1 -> WAIT1 with counter cleared; ONE: sync=0 -> WAIT0 with counter cleared; otherwise hold.
REQ-015 WAIT1: sync=0 -> ZERO (glitch rejected, no output change); sync=1 and counter==STABLE_CYCLES-1 -> ONE; else counter+1.
REQ-016 WAIT0: symmetric to WAIT1 with levels inverted, ending in ONE (rejected) or ZERO (accepted).
REQ-017 Counter width SHALL be $clog2(STABLE_CYCLES) bits; counter SHALL never wrap, since each WAIT state exits at the terminal count.
REQ-018 Latency: debounced SHALL change on the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new noisy level, if noisy holds throughout.
REQ-019 p_edge/n_edge SHALL be high exactly in the first cycle debounced shows its new level, derived from registered state with no combinational path from noisy.
REQ-020 p_edge and n_edge on one channel SHALL never be high together; different channels may pulse in the same cycle.

Reset
REQ-021 reset_n low SHALL immediately force all synchroniser flops, FSMs (ZERO), counters and long-press state to 0 and all outputs to 0.
REQ-022 Reset mid-debounce or mid-press SHALL discard progress; after release, a held-high input SHALL undergo the full REQ-018 latency and produce a p_edge.

Configuration
REQ-023 With LONG_PRESS_EN defined: a per-channel counter of $clog2(LONG_CYCLES+1) bits SHALL run while debounced=1, pulse long_press once when it reaches LONG_CYCLES, saturate, and clear when debounced=0.
REQ-024 Without LONG_PRESS_EN: no long-press counters SHALL be synthesised and long_press SHALL be tied to 0; all other behaviour is unchanged.
REQ-025 A press released before LONG_CYCLES SHALL produce no long_press; a WAIT0 glitch rejected back to ONE SHALL not restart the long-press count.

Structure
REQ-026 Package debouncer_pkg SHALL hold the FSM state enum (ZERO, WAIT1, ONE, WAIT0) and the count-width helper function.
REQ-027 Sub-module debounce_channel (synchroniser, FSM, counters, edge logic for one bit) SHALL be instantiated CH times by a generate loop.

Verification (CH=4, STABLE_CYCLES=8, LONG_CYCLES=32, LONG_PRESS_EN defined)
REQ-028 noisy[0] 0->1 held -> debounced[0] rises on edge 11; p_edge[0] and any_edge[0] high for that one cycle only.
REQ-029 noisy[1] pulses of 5 cycles high / 5 low, repeated 6 times -> debounced[1], p_edge[1] and n_edge[1] stay 0.
REQ-030 noisy[2] held high for 50 cycles -> one p_edge[2], long_press[2] exactly 32 cycles after debounced[2] rises, no second pulse; on release, one n_edge[2].
REQ-031 noisy = 4'b1111 in one cycle -> all four debounced bits and p_edge bits assert on the same edge.
REQ-032 reset_n pulsed low at cycle 5 of a WAIT1 count, noisy held high -> outputs 0 at once; debounced rises 11 edges after reset release.
REQ-033 Build without LONG_PRESS_EN, repeat REQ-030 -> long_press stays 4'b0000; edge timing is identical.
